// File: rtl/freq_pkg.sv
// Shared types and constants for the slow-clock frequency meter.
// HALF holds the half-period (in CLK_50 cycles) of each throttle speed step.
package freq_pkg;

  localparam int CNT_W_DEF     = 25;
  localparam int NUM_STEPS     = 6;
  localparam int TOL_SHIFT_DEF = 6;

  typedef logic [2:0] step_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  typedef struct packed {
    logic  match;
    step_t idx;
  } cls_t;

  // Packed so it can be overridden as a module parameter; element [0] is step 0.
  localparam logic [NUM_STEPS-1:0][31:0] HALF = {
    32'd416000, 32'd500000, 32'd625000, 32'd830000, 32'd12500000, 32'd2500000
  };

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Brings an asynchronous clock into the CLK_50 domain and flags its edges.
// Two synchronizer flops plus a delay flop; rise/fall are one cycle wide.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of a slow clock in CLK_50 cycles and
// classifies the period against the throttle speed-step table.
//
// state | meaning
// IDLE  | waiting for a first rise; counter parked at 0
// HIGH  | clk_in high, counting towards the fall
// LOW   | clk_in low, counting towards the rise that closes the period
module freq_meter
  import freq_pkg::*;
#(
  parameter int                          CNT_W     = CNT_W_DEF,
  parameter int unsigned                 TIMEOUT   = (2**CNT_W) - 1,
  parameter int                          TOL_SHIFT = TOL_SHIFT_DEF,
  parameter logic [NUM_STEPS-1:0][31:0]  HALF_TAB  = HALF
) (
  input  logic             CLK_50,
  input  logic             reset_n,
  input  logic             clk_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output step_t            step_idx,
  output logic             step_match,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic cls_t classify(input logic [CNT_W-1:0] per);
    cls_t        r;
    logic [31:0] p, e, d;
    r = '0;
    p = 32'(per);
    // Walk downwards so the lowest matching step is the one that sticks.
    for (int k = NUM_STEPS - 1; k >= 0; k--) begin
      e = HALF_TAB[k] << 1;
      d = (p > e) ? (p - e) : (e - p);
      if (d <= (e >> TOL_SHIFT)) begin
        r.match = 1'b1;
        r.idx   = step_t'(k);
      end
    end
    return r;
  endfunction

  logic rise, fall;

  edge_sync u_sync (
    .clk   (CLK_50),
    .rst_n (reset_n),
    .d     (clk_in),
    .rise  (rise),
    .fall  (fall)
  );

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [CNT_W-1:0] hi_lat, hi_lat_d;
  logic [CNT_W-1:0] period_d, high_time_d;
  step_t            step_idx_d;
  logic             step_match_d, meas_valid_d, timeout_d, to_hit;
  cls_t             cls;

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_lat     <= '0;
      period     <= '0;
      high_time  <= '0;
      step_idx   <= '0;
      step_match <= 1'b0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      hi_lat     <= hi_lat_d;
      period     <= period_d;
      high_time  <= high_time_d;
      step_idx   <= step_idx_d;
      step_match <= step_match_d;
      meas_valid <= meas_valid_d;
      timeout    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    hi_lat_d     = hi_lat;
    period_d     = period;
    high_time_d  = high_time;
    step_idx_d   = step_idx;
    step_match_d = step_match;
    meas_valid_d = 1'b0;
    timeout_d    = timeout;
    cls          = classify(cnt);
    // Saturate so the counter can never wrap back under the timeout threshold.
    cnt_inc      = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    to_hit       = (cnt >= TO_CNT);

    if (clear) begin
      state_d      = IDLE;
      cnt_d        = '0;
      hi_lat_d     = '0;
      period_d     = '0;
      high_time_d  = '0;
      step_idx_d   = '0;
      step_match_d = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            cnt_d   = CNT_W'(1);
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hi_lat_d = cnt;
            cnt_d    = cnt_inc;
            state_d  = LOW;
          end else if (to_hit) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            period_d     = cnt;
            high_time_d  = hi_lat;
            step_match_d = cls.match;
            if (cls.match) step_idx_d = cls.idx;
            meas_valid_d = 1'b1;
            timeout_d    = 1'b0;
            cnt_d        = CNT_W'(1);
            state_d      = HIGH;
          end else if (to_hit) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter using a 1/1000-scaled step table so every
// scenario fits a short run; u_to carries a small TIMEOUT for the stall case.
module tb_freq_meter;
  import freq_pkg::*;

  localparam int W = 25;
  localparam logic [NUM_STEPS-1:0][31:0] TAB = {
    32'd416, 32'd500, 32'd625, 32'd830, 32'd12500, 32'd2500
  };

  logic         CLK_50, reset_n, clk_in, clear;
  logic [W-1:0] m_period, m_high, t_period, t_high;
  logic         m_valid, m_match, m_to, t_valid, t_match, t_to;
  step_t        m_idx, t_idx;

  int total = 0;
  int bad   = 0;
  int vld   = 0;
  int v0;

  freq_meter #(.CNT_W(W), .HALF_TAB(TAB)) u_main (
    .CLK_50(CLK_50), .reset_n(reset_n), .clk_in(clk_in), .clear(clear),
    .period(m_period), .high_time(m_high), .meas_valid(m_valid),
    .step_idx(m_idx), .step_match(m_match), .timeout(m_to)
  );

  freq_meter #(.CNT_W(W), .TIMEOUT(5000), .HALF_TAB(TAB)) u_to (
    .CLK_50(CLK_50), .reset_n(reset_n), .clk_in(clk_in), .clear(clear),
    .period(t_period), .high_time(t_high), .meas_valid(t_valid),
    .step_idx(t_idx), .step_match(t_match), .timeout(t_to)
  );

  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  always @(negedge CLK_50) if (m_valid) vld++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hold clk_in at v for n CLK_50 rising edges; called and returns at a negedge.
  task automatic phase(input logic v, input int n);
    clk_in = v;
    repeat (n) @(negedge CLK_50);
  endtask

  initial begin
    reset_n = 1'b0;
    clk_in  = 1'b0;
    clear   = 1'b0;
    repeat (3) @(negedge CLK_50);
    reset_n = 1'b1;

    // 1: idle after reset
    repeat (100) @(negedge CLK_50);
    chk("rst_period", 32'(m_period), 0);
    chk("rst_high", 32'(m_high), 0);
    chk("rst_idx", 32'(m_idx), 0);
    chk("rst_match", 32'(m_match), 0);
    chk("rst_timeout", 32'(m_to), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_vld_cnt", 32'(vld), 0);

    // 2: 416/416, three periods -> two measurements, step 5
    for (int i = 0; i < 3; i++) begin
      phase(1'b1, 416);
      phase(1'b0, 416);
    end
    chk("s5_vld_cnt", 32'(vld), 2);
    chk("s5_period", 32'(m_period), 832);
    chk("s5_high", 32'(m_high), 416);
    chk("s5_idx", 32'(m_idx), 5);
    chk("s5_match", 32'(m_match), 1);

    // 3: 12500/12500 -> step 1, then 1000/1000 unmatched keeps idx
    phase(1'b1, 12500);
    phase(1'b0, 12500);
    phase(1'b1, 1000);
    chk("s1_period", 32'(m_period), 25000);
    chk("s1_high", 32'(m_high), 12500);
    chk("s1_idx", 32'(m_idx), 1);
    chk("s1_match", 32'(m_match), 1);
    phase(1'b0, 1000);
    phase(1'b1, 1000);
    chk("nm_period", 32'(m_period), 2000);
    chk("nm_high", 32'(m_high), 1000);
    chk("nm_idx", 32'(m_idx), 1);
    chk("nm_match", 32'(m_match), 0);
    phase(1'b0, 1000);

    // 4: clk_in stuck high, TIMEOUT = 5000 on u_to
    phase(1'b1, 5002);
    chk("to_not_yet", 32'(t_to), 0);
    chk("to_period_pre", 32'(t_period), 2000);
    @(negedge CLK_50);
    chk("to_set", 32'(t_to), 1);
    chk("to_period_hold", 32'(t_period), 2000);
    phase(1'b0, 625);
    phase(1'b1, 625);
    chk("to_after_1st_rise", 32'(t_to), 1);
    phase(1'b0, 625);
    phase(1'b1, 625);
    chk("to_cleared", 32'(t_to), 0);
    chk("to_s3_period", 32'(t_period), 1250);
    chk("to_s3_idx", 32'(t_idx), 3);
    chk("to_s3_match", 32'(t_match), 1);

    // 5: 500/500 with reset pulse mid-LOW
    phase(1'b0, 500);
    phase(1'b1, 500);
    phase(1'b0, 500);
    phase(1'b1, 500);
    chk("s4_pre_period", 32'(m_period), 1000);
    chk("s4_pre_idx", 32'(m_idx), 4);
    phase(1'b0, 200);
    reset_n = 1'b0;
    #1;
    chk("async_period", 32'(m_period), 0);
    chk("async_high", 32'(m_high), 0);
    chk("async_idx", 32'(m_idx), 0);
    chk("async_match", 32'(m_match), 0);
    @(negedge CLK_50);
    reset_n = 1'b1;
    v0 = vld;
    phase(1'b0, 300);
    phase(1'b1, 500);
    chk("rst_no_valid_1st", 32'(vld), 32'(v0));
    phase(1'b0, 500);
    phase(1'b1, 500);
    chk("rst_valid_2nd", 32'(vld), 32'(v0 + 1));
    chk("s4_period", 32'(m_period), 1000);
    chk("s4_high", 32'(m_high), 500);
    chk("s4_idx", 32'(m_idx), 4);
    chk("s4_match", 32'(m_match), 1);

    // 6: clear coinciding with a detected rise
    phase(1'b0, 500);
    v0 = vld;
    clk_in = 1'b1;
    @(negedge CLK_50);
    @(negedge CLK_50);
    clear = 1'b1;
    @(negedge CLK_50);
    clear = 1'b0;
    chk("clr_no_valid", 32'(vld), 32'(v0));
    chk("clr_period", 32'(m_period), 0);
    chk("clr_high", 32'(m_high), 0);
    chk("clr_idx", 32'(m_idx), 0);
    phase(1'b1, 497);
    phase(1'b0, 500);
    phase(1'b1, 500);
    chk("clr_no_valid_1st", 32'(vld), 32'(v0));
    phase(1'b0, 500);
    phase(1'b1, 500);
    chk("clr_valid_2nd", 32'(vld), 32'(v0 + 1));
    chk("clr_s4_period", 32'(m_period), 1000);
    chk("clr_s4_idx", 32'(m_idx), 4);
    chk("clr_s4_match", 32'(m_match), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
